cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port miss_detected, input, 1, a cache miss request from the pipeline; sampled only in IDLE.
REQ-004 SHALL have port miss_address, input, 16, the byte address of the missing access; captured with miss_detected.
REQ-005 SHALL have port memory_data_valid, input, 1, a memory read response valid strobe.
REQ-006 SHALL have port fsm_busy, output, 1, high while a fill is in progress (pipeline stall).
REQ-007 SHALL have port mem_read_en, output, 1, the memory read request strobe, one word per cycle.
REQ-008 SHALL have port mem_addr, output, 16, the word address presented with mem_read_en.
REQ-009 SHALL have port write_data_array, output, 1, the data-array write strobe for the current response.
REQ-010 SHALL have port data_word_sel, output, 3, the word index within the block for write_data_array.
REQ-011 SHALL have port write_tag_array, output, 1, a one-cycle tag/valid write pulse that completes the fill.
REQ-012 SHALL have port fill_block_addr, output, 16, the captured block base (miss_address & 16'hFFF0).

Function
REQ-013 SHALL implement the states IDLE and FILL; IDLE->FILL on miss_detected; FILL->IDLE in the cycle after the 8th response.
REQ-014 SHALL use a block of 8 words x 2 bytes; word address = fill_block_addr + 2*index, and SHALL ignore the low address bit.
REQ-015 SHALL register miss_address and assert fsm_busy from the cycle after miss_detected is sampled high in IDLE.
REQ-016 SHALL assert mem_read_en for exactly 8 consecutive cycles starting with the first FILL cycle, with a 3-bit issue counter stepping the index by 1 per cycle.
REQ-017 SHALL, on each memory_data_valid in FILL, assert write_data_array combinationally in the same cycle, with data_word_sel equal to the response counter's index, and then advance the response counter.
REQ-018 SHALL handle arbitrary response latency, and gaps between responses, via the independent response counter; the issue and response counters SHALL not interact.
REQ-019 SHALL pulse write_tag_array in the same cycle as the 8th write_data_array; fsm_busy SHALL deassert in the following cycle.
REQ-020 SHALL ignore miss_detected during FILL; a miss held high in the cycle fsm_busy falls starts a new fill one cycle later.
REQ-021 SHALL, in IDLE, ignore memory_data_valid (no writes, no counter change).
REQ-022 SHALL wrap the index modulo 8 (7->0) in both counters.

Reset
REQ-023 SHALL, with rst high at a clock edge, go to IDLE, clear both counters, and clear fill_block_addr to 0; fsm_busy, mem_read_en, write_data_array, write_tag_array and data_word_sel SHALL be 0.
REQ-024 SHALL abort an in-progress fill on reset with no tag write; responses arriving after reset SHALL be ignored.

Configuration
REQ-025 SHALL, with macro CACHE_FILL_CRITICAL_FIRST_EN defined, start both counters at miss_address[3:1] and wrap, so the missed word is requested and written first.
REQ-026 SHALL, without CACHE_FILL_CRITICAL_FIRST_EN, start both counters at index 0; all other behaviour SHALL be identical.

Verification
REQ-027 SHALL cover a basic fill: miss_address=16'h1234 with a 4-cycle memory -> mem_addr 1230,1232,...,123E on 8 consecutive cycles; writes with sel 0..7; tag pulse on the 8th; fsm_busy high for 12 cycles.
REQ-028 SHALL cover critical-first (macro on): miss_address=16'h00A6 -> mem_addr 00A6,00A8,00AA,00AC,00AE,00A0,00A2,00A4; sel 3,4,5,6,7,0,1,2.
REQ-029 SHALL cover irregular latency: valid strobes with 0-3 idle gaps between them -> exactly 8 writes, tag pulse only on the 8th valid, no early busy drop.
REQ-030 SHALL cover reset mid-fill: rst after the 5th response, with 3 more valids injected -> no write_data_array, no write_tag_array, all outputs 0.
REQ-031 SHALL cover a back-to-back miss: miss_detected held high through a fill with the next address 16'h2000 -> second fill mem_addr 2000 begins 1 cycle after fsm_busy falls; the held miss is ignored during the first fill.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache block fill sequencer: 8 word reads issued back to back, responses written as they arrive
// Optional macro CACHE_FILL_CRITICAL_FIRST_EN: issue and write the missed word first, then wrap within the block.
module cache_fill_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        memory_data_valid,
   output logic        fsm_busy,
   output logic        mem_read_en,
   output logic [15:0] mem_addr,
   output logic        write_data_array,
   output logic [2:0]  data_word_sel,
   output logic        write_tag_array,
   output logic [15:0] fill_block_addr
);

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   state_t     state;
   logic [2:0] issue_idx;
   logic [3:0] issue_cnt;
   logic [2:0] resp_idx;
   logic [3:0] resp_cnt;
   logic [2:0] start_idx;
   logic       resp_fire;
   logic       last_resp;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
   assign start_idx = miss_address[3:1];
`else
   assign start_idx = 3'd0;
`endif

   // Responses are written in the cycle they arrive; the issue side never waits on them.
   assign resp_fire        = (state == FILL) && memory_data_valid;
   assign last_resp        = resp_fire && (resp_cnt == 4'd7);
   assign write_data_array = resp_fire;
   assign data_word_sel    = resp_fire ? resp_idx : 3'd0;
   assign write_tag_array  = last_resp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         fsm_busy        <= 1'b0;
         mem_read_en     <= 1'b0;
         mem_addr        <= 16'h0000;
         fill_block_addr <= 16'h0000;
         issue_idx       <= 3'd0;
         issue_cnt       <= 4'd0;
         resp_idx        <= 3'd0;
         resp_cnt        <= 4'd0;
      end else if (state == IDLE) begin
         if (miss_detected) begin
            state           <= FILL;
            fsm_busy        <= 1'b1;
            fill_block_addr <= miss_address & 16'hFFF0;
            mem_read_en     <= 1'b1;
            mem_addr        <= {miss_address[15:4], start_idx, 1'b0};
            issue_idx       <= start_idx + 3'd1;
            issue_cnt       <= 4'd1;
            resp_idx        <= start_idx;
            resp_cnt        <= 4'd0;
         end
      end else begin
         if (issue_cnt < 4'd8) begin
            mem_read_en <= 1'b1;
            mem_addr    <= {fill_block_addr[15:4], issue_idx, 1'b0};
            issue_idx   <= issue_idx + 3'd1;
            issue_cnt   <= issue_cnt + 4'd1;
         end else begin
            mem_read_en <= 1'b0;
         end
         if (resp_fire) begin
            resp_idx <= resp_idx + 3'd1;
            resp_cnt <= resp_cnt + 4'd1;
         end
         if (last_resp) begin
            state       <= IDLE;
            fsm_busy    <= 1'b0;
            mem_read_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm: vector table of fills plus reset and back-to-back sequences
// Expected word order follows CACHE_FILL_CRITICAL_FIRST_EN when the bench is built with it.
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        memory_data_valid;
   logic        fsm_busy;
   logic        mem_read_en;
   logic [15:0] mem_addr;
   logic        write_data_array;
   logic [2:0]  data_word_sel;
   logic        write_tag_array;
   logic [15:0] fill_block_addr;

   int errors = 0;
   int checks = 0;

   logic [15:0] addr_q[$];
   logic [2:0]  sel_q[$];
   int          pend_q[$];

   typedef struct {
      logic [15:0] addr;
      int          lat;
      int          max_gap;
      logic [15:0] exp_base;
      int          exp_busy;
   } vec_t;

   vec_t vecs[5];

   cache_fill_fsm dut (
      .clk(clk),
      .rst(rst),
      .miss_detected(miss_detected),
      .miss_address(miss_address),
      .memory_data_valid(memory_data_valid),
      .fsm_busy(fsm_busy),
      .mem_read_en(mem_read_en),
      .mem_addr(mem_addr),
      .write_data_array(write_data_array),
      .data_word_sel(data_word_sel),
      .write_tag_array(write_tag_array),
      .fill_block_addr(fill_block_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] start_of(input logic [15:0] a);
`ifdef CACHE_FILL_CRITICAL_FIRST_EN
      return a[3:1];
`else
      return 3'd0 & a[2:0];
`endif
   endfunction

   // One complete fill; cycle 1 is the first cycle after the miss is sampled.
   task automatic do_fill(input logic [15:0] addr, input int lat, input int max_gap,
                          input logic [15:0] exp_base, input int exp_busy,
                          input bit chained, input bit hold, input logic [15:0] next_addr);
      int nreads = 0, first_rd = 0, last_rd = 0, nwrites = 0, busy_cnt = 0, next_ok = 0;
      bit done = 0, ended = 0;
      logic [2:0] st;
      if (!chained) begin
         @(posedge clk); #1;
         miss_detected     = 1'b1;
         miss_address      = addr;
         memory_data_valid = 1'b0;
      end
      st = start_of(addr);
      for (int k = 0; k < 8; k++) begin
         logic [2:0] idx;
         idx = st + 3'(k);
         addr_q.push_back(exp_base + {12'h000, idx, 1'b0});
         sel_q.push_back(idx);
      end
      pend_q.delete();
      for (int cyc = 1; cyc <= 150 && !ended; cyc++) begin
         @(posedge clk); #1;
         miss_detected = hold;
         if (hold) miss_address = next_addr;
         memory_data_valid = 1'b0;
         if (pend_q.size() > 0 && pend_q[0] <= cyc && cyc >= next_ok) begin
            memory_data_valid = 1'b1;
            void'(pend_q.pop_front());
            next_ok = cyc + 1 + int'($urandom_range(0, max_gap));
         end
         #1;
         if (done) begin
            chk("busy_drop", 32'(fsm_busy), 32'd0);
            chk("read_after_fill", 32'(mem_read_en), 32'd0);
            ended = 1;
         end else begin
            chk("busy_held", 32'(fsm_busy), 32'd1);
            busy_cnt += int'(fsm_busy);
            if (cyc == 1) chk("block_addr", 32'(fill_block_addr), 32'(exp_base));
            chk("write_strobe", 32'(write_data_array), 32'(memory_data_valid));
            if (mem_read_en) begin
               nreads++;
               if (first_rd == 0) first_rd = cyc;
               last_rd = cyc;
               pend_q.push_back(cyc + lat);
               chk("read_expected", 32'(addr_q.size() > 0), 32'd1);
               if (addr_q.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
            if (write_data_array) begin
               nwrites++;
               chk("write_expected", 32'(sel_q.size() > 0), 32'd1);
               if (sel_q.size() > 0) chk("word_sel", 32'(data_word_sel), 32'(sel_q.pop_front()));
               chk("tag_pulse", 32'(write_tag_array), 32'(nwrites == 8));
               if (nwrites == 8) done = 1;
            end else begin
               chk("tag_idle", 32'(write_tag_array), 32'd0);
            end
         end
      end
      chk("fill_done", 32'(ended), 32'd1);
      chk("read_count", 32'(nreads), 32'd8);
      chk("first_read_cycle", 32'(first_rd), 32'd1);
      chk("last_read_cycle", 32'(last_rd), 32'd8);
      chk("write_count", 32'(nwrites), 32'd8);
      if (exp_busy != 0) chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
      addr_q.delete();
      sel_q.delete();
   endtask

   initial begin
      int nw;
      vecs[0] = '{16'h1234, 4, 0, 16'h1230, 12};
      vecs[1] = '{16'h00A6, 3, 0, 16'h00A0, 11};
      vecs[2] = '{16'hFFFF, 1, 0, 16'hFFF0, 9};
      vecs[3] = '{16'h5678, 2, 3, 16'h5670, 0};
      vecs[4] = '{16'h0001, 5, 2, 16'h0000, 0};

      rst = 1'b1;
      miss_detected = 1'b0;
      miss_address = 16'h0000;
      memory_data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(fsm_busy), 32'd0);
      chk("rst_read_en", 32'(mem_read_en), 32'd0);
      chk("rst_write", 32'(write_data_array), 32'd0);
      chk("rst_tag", 32'(write_tag_array), 32'd0);
      chk("rst_sel", 32'(data_word_sel), 32'd0);
      chk("rst_block_addr", 32'(fill_block_addr), 32'd0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++)
         do_fill(vecs[v].addr, vecs[v].lat, vecs[v].max_gap, vecs[v].exp_base,
                 vecs[v].exp_busy, 1'b0, 1'b0, 16'h0000);

      // Reset after the 5th response, then stray responses must do nothing.
      @(posedge clk); #1;
      miss_detected = 1'b1;
      miss_address = 16'h4442;
      pend_q.delete();
      nw = 0;
      for (int cyc = 1; cyc <= 60 && nw < 5; cyc++) begin
         @(posedge clk); #1;
         miss_detected = 1'b0;
         memory_data_valid = 1'b0;
         if (pend_q.size() > 0 && pend_q[0] <= cyc) begin
            memory_data_valid = 1'b1;
            void'(pend_q.pop_front());
         end
         #1;
         if (mem_read_en) pend_q.push_back(cyc + 2);
         if (write_data_array) nw++;
      end
      chk("pre_reset_writes", 32'(nw), 32'd5);
      @(posedge clk); #1;
      rst = 1'b1;
      memory_data_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         memory_data_valid = 1'b1;
         #1;
         chk("post_rst_write", 32'(write_data_array), 32'd0);
         chk("post_rst_tag", 32'(write_tag_array), 32'd0);
         chk("post_rst_busy", 32'(fsm_busy), 32'd0);
         chk("post_rst_read_en", 32'(mem_read_en), 32'd0);
         chk("post_rst_sel", 32'(data_word_sel), 32'd0);
         chk("post_rst_block_addr", 32'(fill_block_addr), 32'd0);
         @(posedge clk); #1;
      end
      memory_data_valid = 1'b0;
      pend_q.delete();

      // Miss held through a fill: ignored until busy falls, then the next fill starts one cycle later.
      do_fill(16'h3456, 2, 0, 16'h3450, 10, 1'b0, 1'b1, 16'h2000);
      do_fill(16'h2000, 2, 0, 16'h2000, 10, 1'b1, 1'b0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
